// File: rtl/fetch_unit.sv
// Instruction fetch FSM: one outstanding imem request, word held for the decoder until consumed.
// Latency: response in cycle M gives instr_valid in cycle M+1; no new request while a word is held.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirects park the unit in FAULT until an aligned redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, instr_q, instr_pc_q;
  logic        discard_q;
  logic [31:0] redirect_tgt;
  logic        redirect_bad;
  logic        redirect_ok;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redirect_tgt = redirect_pc;
  assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign redirect_bad = 1'b0;
`endif
  assign redirect_ok = redirect_valid && !redirect_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_REQ;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_bad) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_REQ:   if (imem_req_ready) state_d = S_WAIT;
        // A redirect coinciding with the response, or an earlier one, kills the word.
        S_WAIT:  if (imem_rsp_valid) state_d = (discard_q || redirect_valid) ? S_REQ : S_HOLD;
        S_HOLD:  if (redirect_valid || instr_ready) state_d = S_REQ;
        S_FAULT: if (redirect_valid) state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_comb begin
    imem_req_valid = 1'b0;
    instr_valid    = 1'b0;
    fetch_fault    = 1'b0;
    case (state_q)
      S_REQ:   imem_req_valid = !rst;
      S_HOLD:  instr_valid    = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
      S_FAULT: fetch_fault    = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      discard_q  <= 1'b0;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
    end else begin
      if (redirect_ok)
        pc_q <= redirect_tgt;
      else if (state_q == S_HOLD && instr_ready)
        pc_q <= pc_q + 32'd4;

      if (redirect_bad)
        discard_q <= 1'b0;
      else if (state_q == S_REQ && imem_req_ready)
        discard_q <= redirect_valid;
      else if (state_q == S_WAIT)
        discard_q <= imem_rsp_valid ? 1'b0 : (discard_q | redirect_valid);

      if (state_q == S_WAIT && imem_rsp_valid && !discard_q && !redirect_valid) begin
        instr_q    <= imem_rsp_data;
        instr_pc_q <= pc_q;
      end
    end
  end

  assign imem_req_addr = pc_q;
  assign instr         = instr_q;
  assign instr_pc      = instr_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, reset-during-WAIT sequence, then random traffic vs a reference model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        fetch_fault;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .fetch_fault(fetch_fault)
  );

  typedef struct {
    logic        rq_rdy;
    logic        rs_vld;
    logic [31:0] rs_dat;
    logic        rd_vld;
    logic [31:0] rd_pc;
    logic        in_rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic        e_flt;
  } vec_t;

  vec_t vt[25];

  function automatic vec_t mk(input logic rq_rdy, input logic rs_vld, input logic [31:0] rs_dat,
                              input logic rd_vld, input logic [31:0] rd_pc, input logic in_rdy,
                              input logic e_req, input logic [31:0] e_addr, input logic e_iv,
                              input logic [31:0] e_instr, input logic [31:0] e_ipc, input logic e_flt);
    vec_t v;
    v.rq_rdy = rq_rdy; v.rs_vld = rs_vld; v.rs_dat = rs_dat;
    v.rd_vld = rd_vld; v.rd_pc = rd_pc; v.in_rdy = in_rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv;
    v.e_instr = e_instr; v.e_ipc = e_ipc; v.e_flt = e_flt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_fetch_fault", fetch_fault, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model: an outstanding-request bit, a one-entry holding slot and a kill flag.
  logic        m_out, m_drop, m_have, m_flt;
  logic [31:0] m_pc, m_hi, m_hpc;

  task automatic model_reset();
    m_out = 0; m_drop = 0; m_have = 0; m_flt = 0;
    m_pc = RST_PC; m_hi = 0; m_hpc = 0;
  endtask

  task automatic model_step(input logic rq_rdy, input logic rs_vld, input logic [31:0] rs_dat,
                            input logic rd_vld, input logic [31:0] rd_pc, input logic in_rdy);
    logic        bad;
    logic [31:0] t;
`ifdef FETCH_MISALIGN_CHECK_EN
    bad = rd_vld && (rd_pc[1:0] != 2'b00);
    t = rd_pc;
`else
    bad = 1'b0;
    t = {rd_pc[31:2], 2'b00};
`endif
    if (bad) begin
      m_flt = 1; m_out = 0; m_have = 0; m_drop = 0;
    end else if (m_flt) begin
      if (rd_vld) begin m_flt = 0; m_pc = t; end
    end else if (m_have) begin
      if (rd_vld) begin m_have = 0; m_pc = t; end
      else if (in_rdy) begin m_have = 0; m_pc = m_pc + 32'd4; end
    end else if (m_out) begin
      if (rs_vld) begin
        m_out = 0;
        if (!m_drop && !rd_vld) begin m_have = 1; m_hi = rs_dat; m_hpc = m_pc; end
        m_drop = 0;
        if (rd_vld) m_pc = t;
      end else if (rd_vld) begin
        m_drop = 1; m_pc = t;
      end
    end else begin
      if (rq_rdy) begin m_out = 1; m_drop = rd_vld; end
      if (rd_vld) m_pc = t;
    end
  endtask

  initial begin
    logic        e22_req, e23_req, e23_flt;
    logic [31:0] e23_addr;
    logic        r_rq, r_rs, r_rd, r_in, r_rst;
    logic [31:0] r_dat, r_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    e22_req = 1; e23_req = 0; e23_addr = 32'h0; e23_flt = 1;
`else
    e22_req = 1; e23_req = 1; e23_addr = 32'h100; e23_flt = 0;
`endif
    vt[0]  = mk(1,0,0,            0,0,0,             1,32'h0,0,0,0,0);
    vt[1]  = mk(0,1,32'h0000_0093,0,0,0,             0,0,0,0,0,0);
    vt[2]  = mk(0,0,0,            0,0,0,             0,0,1,32'h93,0,0);
    vt[3]  = mk(1,1,32'h1111_1111,0,0,0,             0,0,1,32'h93,0,0);
    vt[4]  = mk(1,1,32'h2222_2222,0,0,0,             0,0,1,32'h93,0,0);
    vt[5]  = mk(1,0,0,            0,0,0,             0,0,1,32'h93,0,0);
    vt[6]  = mk(0,1,32'h3333_3333,0,0,0,             0,0,1,32'h93,0,0);
    vt[7]  = mk(0,0,0,            0,0,1,             0,0,1,32'h93,0,0);
    vt[8]  = mk(1,0,0,            0,0,0,             1,32'h4,0,0,0,0);
    vt[9]  = mk(0,0,0,            1,32'h100,0,       0,0,0,0,0,0);
    vt[10] = mk(0,1,32'hDEAD_BEEF,0,0,0,             0,0,0,0,0,0);
    vt[11] = mk(0,0,0,            1,32'hFFFF_FFFC,0, 1,32'h100,0,0,0,0);
    vt[12] = mk(1,0,0,            0,0,0,             1,32'hFFFF_FFFC,0,0,0,0);
    vt[13] = mk(0,1,32'h1234_5678,0,0,0,             0,0,0,0,0,0);
    vt[14] = mk(0,0,0,            0,0,1,             0,0,1,32'h1234_5678,32'hFFFF_FFFC,0);
    vt[15] = mk(1,0,0,            1,32'h200,0,       1,32'h0,0,0,0,0);
    vt[16] = mk(0,1,32'hAAAA_AAAA,0,0,0,             0,0,0,0,0,0);
    vt[17] = mk(1,0,0,            0,0,0,             1,32'h200,0,0,0,0);
    vt[18] = mk(0,1,32'h5555_5555,1,32'h300,0,       0,0,0,0,0,0);
    vt[19] = mk(1,0,0,            0,0,0,             1,32'h300,0,0,0,0);
    vt[20] = mk(0,1,32'h0000_0BAD,0,0,0,             0,0,0,0,0,0);
    vt[21] = mk(0,0,0,            1,32'h400,0,       0,0,1,32'h0BAD,32'h300,0);
    vt[22] = mk(0,0,0,            1,32'h102,0,       e22_req,32'h400,0,0,0,0);
    vt[23] = mk(0,0,0,            1,32'h200,0,       e23_req,e23_addr,0,0,0,e23_flt);
    vt[24] = mk(0,0,0,            0,0,0,             1,32'h200,0,0,0,0);

    do_reset();
    for (int i = 0; i < 25; i++) begin
      #1;
      chk($sformatf("v%0d_req_valid", i), imem_req_valid, vt[i].e_req);
      if (vt[i].e_req) chk($sformatf("v%0d_req_addr", i), imem_req_addr, vt[i].e_addr);
      chk($sformatf("v%0d_instr_valid", i), instr_valid, vt[i].e_iv);
      if (vt[i].e_iv) begin
        chk($sformatf("v%0d_instr", i), instr, vt[i].e_instr);
        chk($sformatf("v%0d_instr_pc", i), instr_pc, vt[i].e_ipc);
      end
      chk($sformatf("v%0d_fetch_fault", i), fetch_fault, vt[i].e_flt);
      imem_req_ready = vt[i].rq_rdy; imem_rsp_valid = vt[i].rs_vld; imem_rsp_data = vt[i].rs_dat;
      redirect_valid = vt[i].rd_vld; redirect_pc = vt[i].rd_pc; instr_ready = vt[i].in_rdy;
      @(negedge clk);
    end

    // Reset pulsed while a request is outstanding; the late response must be ignored.
    do_reset();
    #1;
    chk("rw_first_req", imem_req_valid, 1);
    chk("rw_first_addr", imem_req_addr, RST_PC);
    imem_req_ready = 1'b1;
    @(negedge clk);
    idle();
    #1;
    chk("rw_wait_req_valid", imem_req_valid, 0);
    rst = 1'b1;
    #1;
    chk("rw_in_rst_req_valid", imem_req_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0BAD;
    #1;
    chk("rw_release_req_valid", imem_req_valid, 1);
    chk("rw_release_addr", imem_req_addr, RST_PC);
    @(negedge clk);
    idle();
    #1;
    chk("rw_late_instr_valid", instr_valid, 0);
    chk("rw_late_req_valid", imem_req_valid, 1);
    chk("rw_late_addr", imem_req_addr, RST_PC);

    // Random traffic against the model, with occasional resets.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      #1;
      chk("rnd_req_valid", imem_req_valid, (!rst && !m_out && !m_have && !m_flt));
      if (!rst && !m_out && !m_have && !m_flt) chk("rnd_req_addr", imem_req_addr, m_pc);
      chk("rnd_instr_valid", instr_valid, m_have);
      if (m_have) begin
        chk("rnd_instr", instr, m_hi);
        chk("rnd_instr_pc", instr_pc, m_hpc);
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("rnd_fetch_fault", fetch_fault, m_flt);
`else
      chk("rnd_fetch_fault", fetch_fault, 0);
`endif
      r_rst = ($urandom_range(0, 299) == 0);
      r_rq  = $urandom_range(0, 1);
      r_rs  = $urandom_range(0, 2) != 0;
      r_dat = $urandom;
      r_rd  = ($urandom_range(0, 7) == 0);
      r_pc  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom;
      if ($urandom_range(0, 3) != 0) r_pc[1:0] = 2'b00;
      r_in  = $urandom_range(0, 1);
      imem_req_ready = r_rq; imem_rsp_valid = r_rs; imem_rsp_data = r_dat;
      redirect_valid = r_rd; redirect_pc = r_pc; instr_ready = r_in;
      rst = r_rst;
      if (r_rst) model_reset();
      else       model_step(r_rq, r_rs, r_dat, r_rd, r_pc, r_in);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
